// File: rtl/button_conditioner.sv
// Multi-channel pushbutton conditioner: sample/slow tick enables, 2-flop sync, debounce, press/release pulses.
// Optional auto-repeat on held buttons when AUTOREPEAT_EN is defined.
module button_conditioner #(
  parameter int CLK_HZ         = 100000000,
  parameter int SAMPLE_HZ      = 1200,
  parameter int SLOW_HZ        = 15,
  parameter int N_CH           = 4,
  parameter int STABLE_SAMPLES = 4,
  parameter int ACTIVE_LOW     = 1,
  parameter int HOLD_SAMPLES   = 600
) (
  input  logic            CLKnexys,
  input  logic            RSTn,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic            tick_sample,
  output logic            tick_slow
);

  localparam int DIV_S = CLK_HZ / SAMPLE_HZ;
  localparam int DIV_L = SAMPLE_HZ / SLOW_HZ;
  localparam int SW    = $clog2(DIV_S);
  localparam int LW    = $clog2(DIV_L);
  localparam int CW    = $clog2(STABLE_SAMPLES) + 1;

  localparam logic [SW-1:0] SAMP_MAX = SW'(DIV_S - 1);
  localparam logic [LW-1:0] SLOW_MAX = LW'(DIV_L - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_SAMPLES - 1);

  logic [SW-1:0]   samp_cnt_q, samp_cnt_d;
  logic [LW-1:0]   slow_cnt_q, slow_cnt_d;
  logic [N_CH-1:0] sync1_q, sync1_d;
  logic [N_CH-1:0] sync2_q;
  logic [N_CH-1:0] level_q, level_d;
  logic [N_CH-1:0] press_q, press_d;
  logic [N_CH-1:0] release_q, release_d;
  logic [CW-1:0]   cnt_q [N_CH];
  logic [CW-1:0]   cnt_d [N_CH];

  assign tick_sample = (samp_cnt_q == SAMP_MAX);
  assign tick_slow   = tick_sample && (slow_cnt_q == SLOW_MAX);

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

  always_comb begin
    samp_cnt_d = tick_sample ? '0 : samp_cnt_q + SW'(1);
    slow_cnt_d = slow_cnt_q;
    if (tick_sample) begin
      slow_cnt_d = (slow_cnt_q == SLOW_MAX) ? '0 : slow_cnt_q + LW'(1);
    end
    // Polarity is corrected ahead of the first flop so sync2_q = 1 always means pressed.
    sync1_d = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;
  end

`ifdef AUTOREPEAT_EN
  localparam int HW = $clog2(HOLD_SAMPLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_SAMPLES);

  logic [HW-1:0] hold_q [N_CH];
  logic [HW-1:0] hold_d [N_CH];
`endif

  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick_sample) begin
        if (sync2_q[i] == level_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          level_d[i]   = ~level_q[i];
          cnt_d[i]     = '0;
          press_d[i]   = ~level_q[i];
          release_d[i] = level_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
`ifdef AUTOREPEAT_EN
    for (int i = 0; i < N_CH; i++) begin
      hold_d[i] = hold_q[i];
      if (!level_q[i]) begin
        hold_d[i] = '0;
      end else if (tick_sample && (hold_q[i] != HOLD_MAX)) begin
        hold_d[i] = hold_q[i] + HW'(1);
      end
      // A repeat is suppressed on the edge where the level falls so press and release never overlap.
      if (tick_slow && (hold_q[i] == HOLD_MAX) && level_d[i]) begin
        press_d[i] = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge CLKnexys or negedge RSTn) begin
    if (!RSTn) begin
      samp_cnt_q <= '0;
      slow_cnt_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      level_q    <= '0;
      press_q    <= '0;
      release_q  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      samp_cnt_q <= samp_cnt_d;
      slow_cnt_q <= slow_cnt_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync1_q;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef AUTOREPEAT_EN
  always_ff @(posedge CLKnexys or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < N_CH; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        hold_q[i] <= hold_d[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: ticks, debounce latency, bounce rejection,
// channel independence, asynchronous reset and (with AUTOREPEAT_EN) auto-repeat.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn;
  logic [3:0] level, press, release_p;
  logic       tick_sample, tick_slow;

  int tests = 0;
  int fails = 0;

  int idx;
  int ts_cnt = 0, ts1 = -1, ts2 = -1;
  int sl_cnt = 0, sl1 = -1, sl2 = -1;
  logic slow_alone = 1'b0;
  logic both_err = 1'b0;
  int press_cnt [4] = '{0, 0, 0, 0};
  int rel_cnt   [4] = '{0, 0, 0, 0};
  int last_press[4] = '{-1, -1, -1, -1};
  int last_rel  [4] = '{-1, -1, -1, -1};
  int pc0       [4];

`ifdef AUTOREPEAT_EN
  localparam int EXP_REPEAT_DELTA = 4;
  localparam int EXP_LAST_PRESS   = 4800;
`else
  localparam int EXP_REPEAT_DELTA = 1;
  localparam int EXP_LAST_PRESS   = 80;
`endif

  button_conditioner #(
    .CLK_HZ(24000), .SAMPLE_HZ(1200), .SLOW_HZ(15), .N_CH(4),
    .STABLE_SAMPLES(4), .ACTIVE_LOW(1), .HOLD_SAMPLES(8)
  ) dut (
    .CLKnexys   (clk),
    .RSTn       (rst_n),
    .btn_raw    (btn),
    .btn_level  (level),
    .btn_press  (press),
    .btn_release(release_p),
    .tick_sample(tick_sample),
    .tick_slow  (tick_slow)
  );

  always #5 clk = ~clk;

  // idx seen between two edges is the index of the next rising edge after reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) idx <= 0;
    else        idx <= idx + 1;
  end

  always @(negedge clk) begin
    if (tick_sample) begin
      ts_cnt <= ts_cnt + 1;
      if (ts_cnt == 0) ts1 <= idx;
      if (ts_cnt == 1) ts2 <= idx;
    end
    if (tick_slow) begin
      sl_cnt <= sl_cnt + 1;
      if (sl_cnt == 0) sl1 <= idx;
      if (sl_cnt == 1) sl2 <= idx;
    end
    if (tick_slow && !tick_sample) slow_alone <= 1'b1;
    if ((press & release_p) != 4'b0) both_err <= 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (press[i]) begin
        press_cnt[i]  <= press_cnt[i] + 1;
        last_press[i] <= idx;
      end
      if (release_p[i]) begin
        rel_cnt[i]  <= rel_cnt[i] + 1;
        last_rel[i] <= idx;
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_idx(input int n);
    while (idx < n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    btn   = 4'hF;
    repeat (3) @(posedge clk);
    #2;
    check("rst_level",   int'(level),       0);
    check("rst_press",   int'(press),       0);
    check("rst_release", int'(release_p),   0);
    check("rst_tick_s",  int'(tick_sample), 0);
    check("rst_tick_l",  int'(tick_slow),   0);
    rst_n = 1'b1;

    // Tick generation
    wait_idx(3300);
    check("tick_s_first",   ts1,    19);
    check("tick_s_second",  ts2,    39);
    check("tick_s_count",   ts_cnt, 165);
    check("tick_l_first",   sl1,    1599);
    check("tick_l_second",  sl2,    3199);
    check("tick_l_alone",   int'(slow_alone), 0);
    check("idle_presses",   press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3], 0);
    check("idle_level",     int'(level), 0);

    // Clean press / release on channel 0
    wait_idx(3400);
    btn[0] = 1'b0;
    wait_idx(3500);
    check("press0_idx",     last_press[0], 3480);
    check("press0_cnt",     press_cnt[0],  1);
    check("press0_latency", int'((last_press[0] - 3400) >= 63 && (last_press[0] - 3400) <= 82), 1);
    check("press0_level",   int'(level),   4'b0001);
    wait_idx(3600);
    btn[0] = 1'b1;
    wait_idx(3700);
    check("rel0_idx",       last_rel[0],   3680);
    check("rel0_cnt",       rel_cnt[0],    1);
    check("rel0_level",     int'(level),   0);
    check("rel0_press_cnt", press_cnt[0],  1);

    // Bounce on channel 1: 15-clock toggles never give four matching samples in a row
    for (int k = 0; k < 20; k++) begin
      wait_idx(3800 + 15 * k);
      btn[1] = k[0];
    end
    wait_idx(4100);
    check("bounce_press",   press_cnt[1], 0);
    check("bounce_rel",     rel_cnt[1],   0);
    check("bounce_level",   int'(level),  0);
    btn[1] = 1'b0;
    wait_idx(4200);
    check("settle_idx",     last_press[1], 4180);
    check("settle_cnt",     press_cnt[1],  1);
    check("settle_level",   int'(level),   4'b0010);

    // Channel independence
    btn[0] = 1'b0;
    wait_idx(4300);
    check("ind_pre_level",  int'(level), 4'b0011);
    btn[0] = 1'b1;
    btn[2] = 1'b0;
    btn[3] = 1'b0;
    wait_idx(4400);
    check("ind_press2_idx", last_press[2], 4380);
    check("ind_press3_idx", last_press[3], 4380);
    check("ind_rel0_idx",   last_rel[0],   4380);
    check("ind_press2_cnt", press_cnt[2],  1);
    check("ind_press3_cnt", press_cnt[3],  1);
    check("ind_ch1_press",  press_cnt[1],  1);
    check("ind_ch1_rel",    rel_cnt[1],    0);
    check("ind_level",      int'(level),   4'b1110);
    check("press_rel_both", int'(both_err), 0);

    // Reset mid-debounce: channel 0 has two matching samples counted at idx 4550
    wait_idx(4500);
    btn[0] = 1'b0;
    wait_idx(4550);
    rst_n = 1'b0;
    #1;
    check("arst_level",     int'(level),     0);
    check("arst_press",     int'(press),     0);
    check("arst_release",   int'(release_p), 0);
    check("arst_tick_s",    int'(tick_sample), 0);
    for (int i = 0; i < 4; i++) pc0[i] = press_cnt[i];
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b1;
    wait_idx(100);
    check("rearm_press0_idx", last_press[0], 80);
    check("rearm_press1_idx", last_press[1], 80);
    check("rearm_press2_idx", last_press[2], 80);
    check("rearm_press3_idx", last_press[3], 80);
    check("rearm_press0_cnt", press_cnt[0] - pc0[0], 1);
    check("rearm_level",      int'(level), 4'hF);

    // Long hold: auto-repeat at every slow tick only when the feature is built in
    wait_idx(6080);
    check("hold_press0_cnt",  press_cnt[0] - pc0[0], EXP_REPEAT_DELTA);
    check("hold_press3_cnt",  press_cnt[3] - pc0[3], EXP_REPEAT_DELTA);
    check("hold_press0_last", last_press[0], EXP_LAST_PRESS);
    check("hold_level",       int'(level), 4'hF);
    check("hold_both",        int'(both_err), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Parametrised multi-channel pushbutton conditioner for the Nexys board front end. It generates one-cycle sample and slow-rate enable ticks from the board clock; these are enables, not derived clocks. Each channel runs a two-flop synchroniser, polarity correction and a saturating-counter debouncer. Per channel it drives a debounced level plus press/release pulses, and an optional auto-repeat. All logic is single-clock; downstream game and control logic consume the ticks and pulses directly.

## Interface
Parameters:
- CLK_HZ, 100000000, board clock frequency
- SAMPLE_HZ, 1200, debounce sampling rate; DIV_S = CLK_HZ/SAMPLE_HZ, must be >= 2
- SLOW_HZ, 15, slow tick rate; DIV_L = SAMPLE_HZ/SLOW_HZ, must be >= 2
- N_CH, 4, number of button channels
- STABLE_SAMPLES, 4, consecutive differing samples needed to flip a level; must be >= 1
- ACTIVE_LOW, 1, 1 = raw input reads 0 when pressed
- HOLD_SAMPLES, 600, auto-repeat hold threshold in sample ticks; used only with AUTOREPEAT_EN

Ports:
- CLKnexys  in  1  system clock; all state on rising edge
- RSTn  in  1  asynchronous, active-low reset
- btn_raw  in  N_CH  raw asynchronous button pins
- btn_level  out  N_CH  debounced level, 1 = pressed
- btn_press  out  N_CH  one-cycle pulse per press event
- btn_release  out  N_CH  one-cycle pulse when a debounced level falls
- tick_sample  out  1  one-cycle pulse at SAMPLE_HZ
- tick_slow  out  1  one-cycle pulse at SLOW_HZ

## Operation
- Reset values: all outputs 0, all counters 0, synchroniser flops hold the "released" value after polarity correction, btn_level 0.
- Sample prescaler:
  - counts 0..DIV_S-1 and wraps to 0;
  - tick_sample is high while the count equals DIV_S-1.
- Slow prescaler:
  - advances only on tick_sample, counts 0..DIV_L-1;
  - tick_slow is high in the cycle where tick_sample is high and the slow count equals DIV_L-1;
  - tick_slow is therefore always coincident with tick_sample.
- Synchroniser: btn_raw passes through two flops every clock. When ACTIVE_LOW = 1 it is inverted before the first flop, so the corrected value s[i] = 1 means pressed.
- Debouncer, per channel i, evaluated only on tick_sample:
  - s[i] == btn_level[i]: the stability counter clears.
  - s[i] != btn_level[i] and counter < STABLE_SAMPLES-1: the counter increments.
  - s[i] != btn_level[i] and counter == STABLE_SAMPLES-1: btn_level[i] toggles and the counter clears.
  - Counter width is $clog2(STABLE_SAMPLES)+1 bits. The counter never exceeds STABLE_SAMPLES-1.
- Pulses:
  - btn_press[i] and btn_release[i] are registered on the same edge that updates btn_level[i];
  - each pulse is high for exactly the first cycle in which the new level is visible;
  - they are never both high.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulses.
- Reset mid-operation immediately forces all state to its reset values, including any in-progress counts and pulses. A button held through reset re-debounces and produces a fresh press.

## Timing
- Synchroniser latency: 2 clocks.
- Raw change to btn_level change: the second synchroniser stage must first present the new value, then STABLE_SAMPLES further tick_sample edges are needed.
  - minimum = 2 + (STABLE_SAMPLES-1)*DIV_S + 1 clocks;
  - maximum = 2 + STABLE_SAMPLES*DIV_S clocks.
- Any bounce back to the old level on a sampled tick restarts the full STABLE_SAMPLES count.
- tick_sample first asserts in clock index DIV_S-1 after RSTn deasserts (first post-reset edge = index 0), then every DIV_S clocks.
- tick_slow first asserts in clock index DIV_S*DIV_L-1.

## Configuration
- Macro: AUTOREPEAT_EN.
- Defined:
  - Each channel adds a hold counter that increments on tick_sample while btn_level[i] = 1 and saturates at HOLD_SAMPLES. It clears when btn_level[i] = 0 and on reset.
  - While the hold counter is saturated, every tick_slow raises an extra one-cycle btn_press[i].
  - If a debounced rising edge coincides with tick_slow, only one btn_press pulse is produced.
- Not defined: no hold counters. btn_press fires only on debounced rising edges.

## Test plan
Bench parameters: CLK_HZ=24000, SAMPLE_HZ=1200, SLOW_HZ=15, N_CH=4, STABLE_SAMPLES=4, ACTIVE_LOW=1; this gives DIV_S=20 and DIV_L=80.

- **Reset and ticks:** release RSTn, btn_raw=4'hF → all outputs 0; tick_sample at clocks 19, 39, 59…; tick_slow at clocks 1599, 3199.
- **Clean press/release:** drive btn_raw[0]=0 and hold → btn_level[0] rises after 63–82 clocks with a single one-cycle btn_press[0]. Then drive btn_raw[0]=1 → single btn_release[0] pulse and btn_level[0] falls.
- **Bounce rejection:** toggle btn_raw[1] every 15 clocks for 300 clocks, then hold it at 0 → no level change or pulse during bouncing; exactly one btn_press[1] after the input settles.
- **Channel independence:** press channels 2 and 3 in the same cycle while channel 0 is releasing → btn_press[2] and btn_press[3] in the same cycle as btn_release[0]; channel 1 outputs stay unchanged.
- **Reset mid-debounce:** assert RSTn=0 while channel 0 has count 2 and btn_level[3]=1 → all outputs 0 asynchronously. After release with the buttons still held → fresh press pulses after the full debounce latency.
- **AUTOREPEAT_EN, HOLD_SAMPLES=8:** hold btn_raw[0]=0 for 6000 clocks → the initial btn_press[0], then one additional pulse at each tick_slow once 8 sample ticks of hold have elapsed. Without the macro, only the initial pulse.
